// File: rtl/relogio_ajuste_ctrl.sv
// Clock-setting controller: RUN -> SET_H -> SET_M -> RUN on btn_mode, with hour/minute increment
// pulses, blink blanking and an idle timeout. Optional hold-to-repeat with macro RELOGIO_AUTO_REPEAT_EN.
module relogio_ajuste_ctrl #(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable1hz,
  input  logic       tick_100hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       inc_h,
  output logic       inc_m,
  output logic       zero_sec,
  output logic [1:0] mode,
  output logic       blank_h,
  output logic       blank_m
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2} state_t;

  localparam int IW = $clog2(TIMEOUT_S + 1);

  state_t         state, state_nx;
  logic [2:0]     mode_sync, inc_sync;  // [1:0] synchronizer, [2] previous sample for edge detect
  logic           mode_rise, inc_rise, in_set, timeout, rep_fire;
  logic           inc_h_nx, inc_m_nx, zero_nx;
  logic [IW-1:0]  idle_cnt;
  logic           blink_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_sync <= '0;
      inc_sync  <= '0;
    end else begin
      mode_sync <= {mode_sync[1:0], btn_mode};
      inc_sync  <= {inc_sync[1:0], btn_inc};
    end
  end

  assign mode_rise = mode_sync[1] & ~mode_sync[2];
  assign inc_rise  = inc_sync[1] & ~inc_sync[2];
  assign in_set    = (state != RUN);
  assign timeout   = in_set & enable1hz & (idle_cnt == IW'(TIMEOUT_S - 1));

`ifdef RELOGIO_AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(RMAX + 1);

  logic [CW-1:0] rep_cnt;
  logic          rep_phase, rep_run, rep_last;

  // Any release or state change drops the counter back to the initial hold delay.
  assign rep_run  = in_set & inc_sync[1] & ~mode_rise & ~timeout;
  assign rep_last = rep_phase ? (rep_cnt == CW'(REPEAT_TICKS - 1))
                              : (rep_cnt == CW'(HOLD_TICKS - 1));
  assign rep_fire = rep_run & tick_100hz & rep_last;

  always_ff @(posedge clock) begin
    if (reset || !rep_run) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (tick_100hz) begin
      if (rep_last) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + CW'(1);
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick_100hz;
  assign rep_fire    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    inc_h_nx = 1'b0;
    inc_m_nx = 1'b0;
    zero_nx  = 1'b0;
    if (mode_rise) begin
      // A simultaneous inc edge is dropped here on purpose.
      case (state)
        RUN:     state_nx = SET_H;
        SET_H:   state_nx = SET_M;
        default: begin
          state_nx = RUN;
          zero_nx  = 1'b1;
        end
      endcase
    end else if (timeout) begin
      state_nx = RUN;
    end else if (in_set && (inc_rise || rep_fire)) begin
      inc_h_nx = (state == SET_H);
      inc_m_nx = (state == SET_M);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      inc_h    <= 1'b0;
      inc_m    <= 1'b0;
      zero_sec <= 1'b0;
    end else begin
      state    <= state_nx;
      inc_h    <= inc_h_nx;
      inc_m    <= inc_m_nx;
      zero_sec <= zero_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !in_set || mode_rise || inc_rise || timeout)
      idle_cnt <= '0;
    else if (enable1hz)
      idle_cnt <= idle_cnt + IW'(1);
  end

  // mode_rise covers both entry into a set state and leaving one.
  always_ff @(posedge clock) begin
    if (reset || !in_set || mode_rise)
      blink_phase <= 1'b0;
    else if (enable1hz)
      blink_phase <= ~blink_phase;
  end

  assign run_en  = (state == RUN);
  assign mode    = state;
  assign blank_h = (state == SET_H) & blink_phase;
  assign blank_m = (state == SET_M) & blink_phase;
endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Randomized self-checking bench for relogio_ajuste_ctrl; pulse counts come from a rule-level model.
module tb_relogio_ajuste_ctrl;
  localparam int HOLD   = 50;
  localparam int REPEAT = 10;
  localparam int TMO    = 30;

  logic clock = 1'b0, reset = 1'b1;
  logic enable1hz = 1'b0, tick_100hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic run_en, inc_h, inc_m, zero_sec, blank_h, blank_m;
  logic [1:0] mode;

  int errors = 0, checks = 0;
  int cnt_h = 0, cnt_m = 0, cnt_z = 0, viol = 0;

  relogio_ajuste_ctrl #(.HOLD_TICKS(HOLD), .REPEAT_TICKS(REPEAT), .TIMEOUT_S(TMO)) dut (
    .clock(clock), .reset(reset), .enable1hz(enable1hz), .tick_100hz(tick_100hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .run_en(run_en), .inc_h(inc_h), .inc_m(inc_m),
    .zero_sec(zero_sec), .mode(mode), .blank_h(blank_h), .blank_m(blank_m));

  always #5 clock = ~clock;

  // Pulse monitor; also records any inc pulse outside its own state or both at once.
  always @(negedge clock) begin
    if (!reset) begin
      if (inc_h) cnt_h++;
      if (inc_m) cnt_m++;
      if (zero_sec) cnt_z++;
      if ((inc_h && inc_m) || (inc_h && mode != 2'd1) || (inc_m && mode != 2'd2)) viol++;
    end
  end

  // Expected number of increments for one press held through n ticks.
  function automatic int model_hold(input int n);
`ifdef RELOGIO_AUTO_REPEAT_EN
    if (n < HOLD) return 1;
    return 2 + (n - HOLD) / REPEAT;
`else
    return 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; enable1hz = 1'b0; tick_100hz = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic press_mode();
    @(negedge clock); btn_mode = 1'b1;
    repeat (4) @(negedge clock); btn_mode = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_1hz();
    repeat ($urandom_range(1, 4)) @(negedge clock);
    enable1hz = 1'b1;
    @(negedge clock); enable1hz = 1'b0;
  endtask

  task automatic pulse_tick();
    repeat ($urandom_range(1, 3)) @(negedge clock);
    tick_100hz = 1'b1;
    @(negedge clock); tick_100hz = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({mode, run_en, inc_h, inc_m, zero_sec, blank_h, blank_m} !== 8'b00_1_00000) begin
      errors++;
      $display("FAIL reset_state: got mode=%0d run_en=%b inc_h=%b inc_m=%b zero=%b bh=%b bm=%b, want 0,1,0,0,0,0,0",
               mode, run_en, inc_h, inc_m, zero_sec, blank_h, blank_m);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [3] = '{2'd1, 2'd2, 2'd0};
    logic       exp_run  [3] = '{1'b0, 1'b0, 1'b1};
    int         exp_z    [3] = '{0, 0, 1};
    int z0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      z0 = cnt_z;
      press_mode();
      checks++;
      if (mode !== exp_mode[i] || run_en !== exp_run[i]) begin
        errors++;
        $display("FAIL mode_cycle[%0d]: got mode=%0d run_en=%b, want mode=%0d run_en=%b",
                 i, mode, run_en, exp_mode[i], exp_run[i]);
      end
      checks++;
      if (cnt_z - z0 !== exp_z[i]) begin
        errors++;
        $display("FAIL zero_sec[%0d]: got %0d pulses, want %0d", i, cnt_z - z0, exp_z[i]);
      end
    end
  endtask

  task automatic test_inc_presses();
    int h0, m0;
    do_reset();
    press_mode();
    h0 = cnt_h; m0 = cnt_m;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      btn_inc = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (inc_h !== 1'b0) begin
        errors++;
        $display("FAIL inc_early[%0d]: inc_h=%b after 2 edges, want 0", i, inc_h);
      end
      @(posedge clock); #1;
      checks++;
      if (inc_h !== 1'b1 || inc_m !== 1'b0) begin
        errors++;
        $display("FAIL inc_latency[%0d]: inc_h=%b inc_m=%b after 3 edges, want 1,0", i, inc_h, inc_m);
      end
      @(posedge clock); #1;
      checks++;
      if (inc_h !== 1'b0) begin
        errors++;
        $display("FAIL inc_width[%0d]: inc_h=%b on 4th edge, want 0", i, inc_h);
      end
      repeat ($urandom_range(1, 6)) @(negedge clock);
      btn_inc = 1'b0;
      repeat (4) @(negedge clock);
    end
    checks++;
    if (cnt_h - h0 !== 5 || cnt_m - m0 !== 0) begin
      errors++;
      $display("FAIL inc_count: got inc_h=%0d inc_m=%0d, want 5,0", cnt_h - h0, cnt_m - m0);
    end
  endtask

  task automatic test_run_ignores_inc();
    int h0, m0;
    do_reset();
    h0 = cnt_h; m0 = cnt_m;
    @(negedge clock); btn_inc = 1'b1;
    repeat (6) pulse_tick();
    btn_inc = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (cnt_h != h0 || cnt_m != m0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL run_ignore: got inc_h=%0d inc_m=%0d mode=%0d, want 0,0,0", cnt_h - h0, cnt_m - m0, mode);
    end
  endtask

  task automatic test_timeout();
    int z0;
    do_reset();
    press_mode(); press_mode();
    z0 = cnt_z;
    for (int k = 1; k <= TMO; k++) begin
      pulse_1hz();
      checks++;
      if (mode !== ((k < TMO) ? 2'd2 : 2'd0) || blank_m !== ((k < TMO) ? k[0] : 1'b0) || blank_h !== 1'b0) begin
        errors++;
        $display("FAIL timeout[%0d]: got mode=%0d blank_m=%b blank_h=%b, want mode=%0d blank_m=%b blank_h=0",
                 k, mode, blank_m, blank_h, (k < TMO) ? 2 : 0, (k < TMO) ? k[0] : 1'b0);
      end
    end
    checks++;
    if (cnt_z != z0) begin
      errors++;
      $display("FAIL timeout_zero: got %0d zero_sec pulses, want 0", cnt_z - z0);
    end
  endtask

  task automatic test_same_cycle();
    int h0;
    do_reset();
    press_mode();
    h0 = cnt_h;
    @(negedge clock); btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (4) @(negedge clock); btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (mode !== 2'd2 || cnt_h != h0) begin
      errors++;
      $display("FAIL same_cycle: got mode=%0d inc_h=%0d, want mode=2 inc_h=0", mode, cnt_h - h0);
    end
  endtask

  task automatic test_hold(input int n);
    int h0, exp;
    do_reset();
    press_mode();
    h0 = cnt_h;
    exp = model_hold(n);
    @(negedge clock); btn_inc = 1'b1;
    repeat (4) @(negedge clock);
    for (int t = 0; t < n; t++) pulse_tick();
    btn_inc = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (cnt_h - h0 !== exp) begin
      errors++;
      $display("FAIL hold_%0d: got %0d inc_h pulses, want %0d", n, cnt_h - h0, exp);
    end
  endtask

  task automatic test_reset_during_hold();
    int h0;
    do_reset();
    press_mode();
    @(negedge clock); btn_inc = 1'b1;
    repeat (4) @(negedge clock);
    for (int t = 0; t < 60; t++) pulse_tick();
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (mode !== 2'd0 || inc_h !== 1'b0 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold_a: got mode=%0d inc_h=%b run_en=%b, want 0,0,1", mode, inc_h, run_en);
    end
    @(posedge clock); #1;
    checks++;
    if (inc_h !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_b: inc_h=%b, want 0", inc_h);
    end
    @(negedge clock); reset = 1'b0;
    h0 = cnt_h;
    for (int t = 0; t < 40; t++) pulse_tick();
    btn_inc = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (cnt_h != h0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold_after: got %0d inc_h, mode=%0d, want 0,0", cnt_h - h0, mode);
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_inc_presses();
    test_run_ignores_inc();
    test_timeout();
    test_same_cycle();
    test_hold(80);
    test_hold($urandom_range(1, 100));
    test_reset_during_hold();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL exclusivity: %0d cycles with inc outside its state or both set, want 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
